// File: rtl/bitcell_ctrl_pkg.sv
// bitcell_ctrl_pkg: shared FSM states, requester IDs and word-select decode.
package bitcell_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, VERIFY} state_t;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/bitcell_array_ctrl_if.sv
// bitcell_array_ctrl_if: requester A/B handshakes plus the bitcell array bus.
interface bitcell_array_ctrl_if #(
    parameter int WORDS = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WORDS)
);
    logic a_req, a_we, a_gnt, a_ack;
    logic [AW-1:0] a_addr;
    logic [WIDTH-1:0] a_wdata, a_rdata;
    logic b_req, b_we, b_gnt, b_ack;
    logic [AW-1:0] b_addr;
    logic [WIDTH-1:0] b_wdata, b_rdata;
    logic [WORDS-1:0] arr_sel;
    logic arr_r_w;
    logic [WIDTH-1:0] arr_in, arr_out;
    logic busy, err;
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, arr_out,
        input a_gnt, a_ack, a_rdata, b_gnt, b_ack, b_rdata, arr_sel, arr_r_w, arr_in, busy, err
    );
    modport slave (
        input a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, arr_out,
        output a_gnt, a_ack, a_rdata, b_gnt, b_ack, b_rdata, arr_sel, arr_r_w, arr_in, busy, err
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2
    import bitcell_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       id
);
    logic last;
    assign id  = &req ? ~last : req[1];
    assign gnt = en ? req & (id ? 2'b10 : 2'b01) : 2'b00;
    // Reset to "B granted last" so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) last <= REQ_B;
        else if (|gnt) last <= id;
    end
endmodule

// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl: arbitrates A/B and sequences read/write accesses to a WORDS x WIDTH bitcell array.
// Define BITCELL_CTRL_READBACK_EN to add a post-write VERIFY read that sets err on mismatch.
module bitcell_array_ctrl
    import bitcell_ctrl_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int WIDTH = 8,
    parameter int WRITE_CYCLES = 2,
    localparam int AW = $clog2(WORDS)
) (
    input logic clk,
    input logic rst_n,
    bitcell_array_ctrl_if.slave bus
);
    localparam int CW = WRITE_CYCLES > 1 ? $clog2(WRITE_CYCLES) : 1;
    state_t state, nxt;
    logic [1:0] gnt;
    logic win, win_we, cmd_id;
    logic [AW-1:0] win_addr, cmd_addr;
    logic [WIDTH-1:0] win_wdata, cmd_wdata, rd_word;
    logic [CW-1:0] cnt;
    logic [WORDS-1:0] sel_word;

    rr_arbiter2 u_arb (.clk, .rst_n, .req({bus.b_req, bus.a_req}), .en(state == IDLE), .gnt, .id(win));

    assign win_we    = win ? bus.b_we : bus.a_we;
    assign win_addr  = win ? bus.b_addr : bus.a_addr;
    assign win_wdata = win ? bus.b_wdata : bus.a_wdata;
    // Out-of-range addresses decode to an all-zero select.
    assign sel_word  = WORDS'(onehot(32'(cmd_addr)));
    assign rd_word   = |bus.arr_sel ? bus.arr_out : '0;
    assign bus.a_ack = state == DONE && cmd_id == REQ_A;
    assign bus.b_ack = state == DONE && cmd_id == REQ_B;
    assign bus.busy  = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        bus.arr_sel = '0;
        bus.arr_r_w = 1'b0;
        bus.arr_in = '0;
        unique case (state)
            IDLE: if (|gnt) nxt = win_we ? WRITE : READ;
            WRITE: begin
                bus.arr_sel = sel_word;
                bus.arr_r_w = |sel_word;
                bus.arr_in = cmd_wdata;
`ifdef BITCELL_CTRL_READBACK_EN
                if (cnt == '0) nxt = VERIFY;
`else
                if (cnt == '0) nxt = DONE;
`endif
            end
            READ, VERIFY: begin
                bus.arr_sel = sel_word;
                nxt = DONE;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.a_gnt <= 1'b0;
            bus.b_gnt <= 1'b0;
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
            bus.err <= 1'b0;
            cmd_id <= REQ_A;
            cmd_addr <= '0;
            cmd_wdata <= '0;
            cnt <= '0;
        end else begin
            bus.a_gnt <= gnt[0];
            bus.b_gnt <= gnt[1];
            if (|gnt) begin
                cmd_id <= win;
                cmd_addr <= win_addr;
                cmd_wdata <= win_wdata;
                cnt <= CW'(WRITE_CYCLES - 1);
                if (int'(win_addr) >= WORDS) bus.err <= 1'b1;
            end
            if (state == WRITE) cnt <= cnt - 1'b1;
            if (state == READ && cmd_id == REQ_A) bus.a_rdata <= rd_word;
            if (state == READ && cmd_id == REQ_B) bus.b_rdata <= rd_word;
`ifdef BITCELL_CTRL_READBACK_EN
            if (state == VERIFY && bus.arr_out != cmd_wdata) bus.err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb_bitcell_array_ctrl: directed checks of arbitration, access timing, reset abort and err handling.
module tb_bitcell_array_ctrl;
    localparam int WC = 2;
`ifdef BITCELL_CTRL_READBACK_EN
    localparam int WLAT = WC + 1;
    localparam logic RB_ERR = 1'b1;
`else
    localparam int WLAT = WC;
    localparam logic RB_ERR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stuck0 = 1'b0;
    int checks = 0;
    int failures = 0;
    int viol = 0;
    logic [7:0] mem [4] = '{default: 8'h00};
    logic [7:0] mem3 [3] = '{default: 8'h5A};
    logic [7:0] out4, out3;
    logic [3:0] prev_sel = '0;
    logic prev_rw = 1'b0;

    bitcell_array_ctrl_if #(.WORDS(4), .WIDTH(8)) bus ();
    bitcell_array_ctrl_if #(.WORDS(3), .WIDTH(8)) bus3 ();
    bitcell_array_ctrl #(.WORDS(4), .WIDTH(8), .WRITE_CYCLES(WC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    bitcell_array_ctrl #(.WORDS(3), .WIDTH(8), .WRITE_CYCLES(WC)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    always #5 clk = ~clk;

    // Bitcell array models: selected words OR onto arr_out; optional stuck-at-0 on bit 0.
    always_comb begin
        out4 = '0;
        for (int i = 0; i < 4; i++) if (bus.arr_sel[i]) out4 = out4 | mem[i];
        if (stuck0) out4[0] = 1'b0;
        out3 = '0;
        for (int i = 0; i < 3; i++) if (bus3.arr_sel[i]) out3 = out3 | mem3[i];
    end
    assign bus.arr_out = out4;
    assign bus3.arr_out = out3;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (bus.arr_r_w && bus.arr_sel[i]) mem[i] <= bus.arr_in;
        for (int i = 0; i < 3; i++) if (bus3.arr_r_w && bus3.arr_sel[i]) mem3[i] <= bus3.arr_in;
    end

    always @(negedge clk) begin
        if (rst_n && ((bus.arr_r_w && bus.arr_sel == '0) || !$onehot0(bus.arr_sel) ||
            (!bus.busy && bus.arr_sel != '0) || ((bus.a_ack || bus.b_ack) && bus.arr_sel != '0) ||
            (prev_rw && bus.arr_r_w && bus.arr_sel != prev_sel)))
            viol <= viol + 1;
        prev_sel <= bus.arr_sel;
        prev_rw <= bus.arr_r_w;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic who, input logic we, input logic [1:0] addr, input logic [7:0] wd,
                          output int gl, output int al, output int rwc, output logic [3:0] sg, output logic rg);
        gl = -1; al = -1; rwc = 0; sg = '0; rg = 1'b0;
        if (who) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        for (int c = 1; c <= 10 && gl < 0; c++) begin
            tick();
            if (who ? bus.b_gnt : bus.a_gnt) begin
                gl = c; sg = bus.arr_sel; rg = bus.arr_r_w; rwc += int'(bus.arr_r_w);
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        for (int c = 1; c <= 10 && al < 0; c++) begin
            tick();
            if (who ? bus.b_ack : bus.a_ack) al = c;
            rwc += int'(bus.arr_r_w);
        end
        tick();
    endtask

    task automatic xfer(input string t, input logic who, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
        int gl, al, rwc;
        logic [3:0] sg, esel;
        logic rg;
        esel = 4'b0001 << addr;
        access(who, we, addr, wd, gl, al, rwc, sg, rg);
        chk({t, "_gnt_lat"}, gl, 1);
        chk({t, "_ack_lat"}, al, we ? WLAT : 1);
        chk({t, "_rw_cycles"}, rwc, we ? WC : 0);
        chk({t, "_sel"}, sg, esel);
        chk({t, "_rw"}, rg, we);
        if (!we) chk({t, "_rdata"}, who ? bus.b_rdata : bus.a_rdata, exp_rd);
    endtask

    task automatic both_read(input logic [1:0] aa, input logic [1:0] ab, output int ga, output int gb);
        ga = -1; gb = -1;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = aa;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = ab;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.a_gnt) begin ga = c; bus.a_req = 1'b0; end
            if (bus.b_gnt) begin gb = c; bus.b_req = 1'b0; end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    task automatic acc3(input string t, input logic [1:0] addr, input logic [2:0] esel,
                        input logic [7:0] erd, input logic eerr);
        bus3.a_req = 1'b1; bus3.a_we = 1'b0; bus3.a_addr = addr;
        tick();
        bus3.a_req = 1'b0;
        chk({t, "_gnt"}, bus3.a_gnt, 1);
        chk({t, "_sel"}, bus3.arr_sel, esel);
        tick();
        chk({t, "_ack"}, bus3.a_ack, 1);
        chk({t, "_rdata"}, bus3.a_rdata, erd);
        chk({t, "_err"}, bus3.err, eerr);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ga, gb;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
        bus3.a_req = 0; bus3.a_we = 0; bus3.a_addr = 0; bus3.a_wdata = 0;
        bus3.b_req = 0; bus3.b_we = 0; bus3.b_addr = 0; bus3.b_wdata = 0;
        repeat (2) tick();
        chk("rst_sel", bus.arr_sel, 0);
        chk("rst_rw", bus.arr_r_w, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
        rst_n = 1'b1;
        tick();
        xfer("t1_wr", 1'b0, 1'b1, 2'd2, 8'hA5, 8'h00);
        xfer("t1_rd", 1'b0, 1'b0, 2'd2, 8'h00, 8'hA5);
        xfer("t3_wr", 1'b1, 1'b1, 2'd1, 8'h3C, 8'h00);
        xfer("t3_rd0", 1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        xfer("t3_rd1", 1'b1, 1'b0, 2'd1, 8'h00, 8'h3C);
        // Arbitration: tie after reset goes to A, then alternates.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        both_read(2'd1, 2'd2, ga, gb);
        chk("t2_r1_a", ga, 1);
        chk("t2_r1_b", gb, 4);
        chk("t2_r1_ardata", bus.a_rdata, 8'h3C);
        chk("t2_r1_brdata", bus.b_rdata, 8'hA5);
        both_read(2'd2, 2'd1, ga, gb);
        chk("t2_r2_a", ga, 1);
        chk("t2_r2_b", gb, 4);
        chk("t2_r2_ardata", bus.a_rdata, 8'hA5);
        chk("t2_r2_brdata", bus.b_rdata, 8'h3C);
        xfer("t2_a_alone", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        both_read(2'd1, 2'd2, ga, gb);
        chk("t2_r3_a", ga, 4);
        chk("t2_r3_b", gb, 1);
        // Reset during the second write cycle aborts without an ack.
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 2'd3; bus.a_wdata = 8'h77;
        tick();
        chk("t4_gnt", bus.a_gnt, 1);
        bus.a_req = 1'b0;
        tick();
        chk("t4_w2_rw", bus.arr_r_w, 1);
        rst_n = 1'b0;
        tick();
        chk("t4_sel", bus.arr_sel, 0);
        chk("t4_rw", bus.arr_r_w, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_ack", bus.a_ack, 0);
        rst_n = 1'b1;
        tick();
        chk("t4_ack_post", bus.a_ack, 0);
        xfer("t4_after", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        chk("err_clean", bus.err, 0);
        acc3("t5_ok", 2'd1, 3'b010, 8'h5A, 1'b0);
        acc3("t5_oor", 2'd3, 3'b000, 8'h00, 1'b1);
        acc3("t5_sticky", 2'd0, 3'b001, 8'h5A, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        stuck0 = 1'b1;
        xfer("t6_w02", 1'b0, 1'b1, 2'd3, 8'h02, 8'h00);
        chk("t6_err02", bus.err, 0);
        xfer("t6_w01", 1'b0, 1'b1, 2'd3, 8'h01, 8'h00);
        chk("t6_err01", bus.err, RB_ERR);
        chk("dir_order_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitcell_array_ctrl.md
Name: bitcell_array_ctrl

Overview:
Sequences read and write accesses to a WORDS x WIDTH array of NAND-latch bitcells. Each bitcell has per-word `sel`, a shared `r_w`, per-bit `in`, and an `out` that is gated by `sel`.
Two requesters (A, B) share the array through a round-robin arbiter. The block drives the word select, direction and write data, and captures the selected word's outputs on reads. It sits between the bitcell array and the requesting logic.

Parameters:
- WORDS, 4, number of words (rows). One `sel` line per word.
- WIDTH, 8, bits per word.
- WRITE_CYCLES, 2, cycles that `sel` and `r_w=1` are held during a write. Minimum 1.
- AW, $clog2(WORDS), address width. Derived; not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- a_req  in  1  requester A access request; held until a_gnt
- a_we  in  1  A: 1=write, 0=read
- a_addr  in  AW  A word address
- a_wdata  in  WIDTH  A write data
- a_gnt  out  1  A command accepted (1-cycle pulse)
- a_ack  out  1  A access complete (1-cycle pulse)
- a_rdata  out  WIDTH  A read data; valid when a_ack follows a read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_ack, b_rdata: same as the A ports, for requester B
- arr_sel  out  WORDS  one-hot word select to bitcells
- arr_r_w  out  1  1=write, 0=read/hold
- arr_in  out  WIDTH  write data to bitcells
- arr_out  in  WIDTH  OR of all words' `out`; zero when no word is selected
- busy  out  1  FSM not in IDLE
- err  out  1  sticky error flag (see Behaviour / Optional Feature)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`.
- Reset values: all outputs 0, so arr_sel=0, arr_r_w=0 (read mode; cells hold), rdata=0, err=0. FSM goes to IDLE and the round-robin pointer favours A.
- FSM states: IDLE, WRITE, READ, DONE (plus VERIFY when the optional feature is compiled in).
- IDLE, on a clock edge with any req=1:
  - Pick the winner.
  - Latch its we/addr/wdata and requester ID into cmd registers.
  - Assert the winner's gnt (registered) for exactly the next cycle.
  - Go to WRITE if we=1, else READ.
  - Requesters drop req after seeing gnt. Because the FSM has left IDLE, a req still high during the gnt cycle is never re-granted.
- Arbitration:
  - A alone or B alone: that requester wins.
  - Both requesting: the one not granted last wins.
  - The pointer updates on every grant.
- WRITE:
  - arr_sel=onehot(addr), arr_r_w=1, arr_in=wdata for WRITE_CYCLES cycles, counted by a down-counter.
  - Then go to DONE.
- READ:
  - arr_sel=onehot(addr), arr_r_w=0 for 1 cycle.
  - At the end of that cycle, capture arr_out into the winner's rdata register, then go to DONE.
- DONE:
  - arr_sel=0, arr_r_w=0, arr_in=0.
  - Winner's ack=1 for this one cycle, then go to IDLE.
- Timing:
  - Read: gnt at cycle N, ack/rdata at N+1.
  - Write: gnt at N (first WRITE cycle), ack at N+WRITE_CYCLES.
  - Minimum spacing between grants is 3 cycles (read).
- Direction ordering: arr_r_w is never 1 while arr_sel=0, and is deasserted in the same cycle as arr_sel. There is no cycle where sel changes word while r_w=1.
- Out-of-range address (addr >= WORDS, possible when WORDS is not a power of 2):
  - Still granted, but arr_sel stays 0.
  - Read returns 0; write has no effect.
  - err is set. err is sticky until reset.
- rdata holds its last value until the next read for that requester.
- Reset mid-operation: on the next edge, return to IDLE with all outputs at reset values. No ack is issued. The cell content of an interrupted write is undefined.

Optional Feature:
- Macro: BITCELL_CTRL_READBACK_EN.
- Defined: after the last WRITE cycle the FSM enters VERIFY.
  - VERIFY: arr_sel=onehot(addr), arr_r_w=0 for 1 cycle, comparing arr_out with the latched wdata.
  - Mismatch sets err.
  - Then go to DONE. Write ack latency becomes WRITE_CYCLES+1.
- Undefined: no VERIFY state; write timing is as in Behaviour.

Decomposition:
- Package bitcell_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, READ, DONE, VERIFY);
  - requester-ID constants REQ_A=0, REQ_B=1;
  - a onehot-decode function.
- Sub-module rr_arbiter2:
  - 2-input round-robin arbiter.
  - Inputs: req[1:0], a grant-enable strobe.
  - Outputs: one-hot grant and the winner ID.

Test Plan:
1. Reset, then A writes 8'hA5 to addr 2 (WRITE_CYCLES=2) -> a_gnt at cycle 1, arr_sel=4'b0100 with arr_r_w=1 for cycles 1-2, a_ack at cycle 3. A then reads addr 2 -> a_rdata=8'hA5 one cycle after a_gnt.
2. A and B request reads in the same cycle after reset -> A granted first, B granted 3 cycles later. Both requesting again -> B is not favoured twice in a row; grants alternate.
3. B writes 8'h3C to addr 1, then B reads addr 0 (never written since reset-cleared stimulus) and addr 1 -> b_rdata=8'h3C for addr 1. arr_sel is exactly one-hot during each access and 0 in IDLE/DONE.
4. rst_n driven low during the 2nd WRITE cycle -> next edge: arr_sel=0, arr_r_w=0, busy=0, no a_ack. A fresh request after reset is granted normally.
5. WORDS=3, read addr 3 -> arr_sel=0, rdata=0, err=1, and err stays 1 through later valid accesses.
6. With BITCELL_CTRL_READBACK_EN defined and the bench model forcing bit 0 of arr_out low -> writing 8'h01 gives ack at WRITE_CYCLES+1 and err=1. Writing 8'h02 leaves err at 0 (from reset).
